// File: rtl/controlador_fsm_pkg.sv
// Shared constants for the FIFO controller: one-hot state codes and the
// threshold values loaded on reset. Arbiters and FIFOs import this too.
package controlador_fsm_pkg;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } estado_t;

  localparam int unsigned N_FIFOS_DEF      = 8;
  localparam int unsigned UMB_W_DEF        = 3;
  localparam int unsigned UMB_ALTO_RST_DEF = 6;
  localparam int unsigned UMB_BAJO_RST_DEF = 1;

endpackage

// File: rtl/controlador_fsm_cfg_validador.sv
// Threshold sanity check: a configuration is usable only when the
// almost-empty threshold is strictly below the almost-full threshold.
module cfg_validador
  import controlador_fsm_pkg::*;
#(
  parameter int unsigned UMB_W = UMB_W_DEF
) (
  input  logic [UMB_W-1:0] umb_alto_in,
  input  logic [UMB_W-1:0] umb_bajo_in,
  output logic             cfg_ok
);

  // Pure compare, consumed by the parent's next-state logic
  always_comb begin
    cfg_ok = (umb_bajo_in < umb_alto_in);
  end

endmodule

// File: rtl/controlador_fsm.sv
// Central controller for the naranja/morado FIFOs: holds the active
// thresholds, tracks whether any FIFO has data, and latches FIFO errors.
module controlador_fsm
  import controlador_fsm_pkg::*;
#(
  parameter int unsigned N_FIFOS      = N_FIFOS_DEF,
  parameter int unsigned UMB_W        = UMB_W_DEF,
  parameter int unsigned UMB_ALTO_RST = UMB_ALTO_RST_DEF,
  parameter int unsigned UMB_BAJO_RST = UMB_BAJO_RST_DEF
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               init,
  input  logic [UMB_W-1:0]   umb_alto_in,
  input  logic [UMB_W-1:0]   umb_bajo_in,
  input  logic [N_FIFOS-1:0] empties,
  input  logic [N_FIFOS-1:0] fifo_err,
  output logic [4:0]         state,
  output logic [UMB_W-1:0]   umb_alto,
  output logic [UMB_W-1:0]   umb_bajo,
  output logic               idle,
  output logic               error_out,
  output logic [N_FIFOS-1:0] err_src
);

  estado_t state_q, state_d;
  logic    cfg_ok;

  cfg_validador #(.UMB_W(UMB_W)) u_cfg_validador (
    .umb_alto_in (umb_alto_in),
    .umb_bajo_in (umb_bajo_in),
    .cfg_ok      (cfg_ok)
  );

  // Next-state: errors beat init, init beats FIFO activity; ERROR is absorbing
  always_comb begin
    state_d = ST_RESET;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT: begin
        if (init)        state_d = ST_INIT;
        else if (cfg_ok) state_d = ST_IDLE;
        else             state_d = ST_ERROR;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (|fifo_err)          state_d = ST_ERROR;
        else if (init)          state_d = ST_INIT;
        else if (empties == '1) state_d = ST_IDLE;
        else                    state_d = ST_ACTIVE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_RESET;
    else          state_q <= state_d;
  end

  // Thresholds follow the inputs only while configuring
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      umb_alto <= UMB_W'(UMB_ALTO_RST);
      umb_bajo <= UMB_W'(UMB_BAJO_RST);
    end else if (state_q == ST_INIT) begin
      umb_alto <= umb_alto_in;
      umb_bajo <= umb_bajo_in;
    end
  end

  // Sticky error source; cleared when (re)entering configuration
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_src <= '0;
    end else if (state_d == ST_INIT) begin
      err_src <= '0;
    end else if (state_q != ST_RESET && state_q != ST_INIT) begin
      err_src <= err_src | fifo_err;
    end
  end

  // Moore decodes straight off the state register
  always_comb begin
    state     = state_q;
    idle      = (state_q == ST_IDLE);
    error_out = (state_q == ST_ERROR);
  end

endmodule

// File: tb/tb_controlador_fsm.sv
// Self-checking bench for controlador_fsm: directed table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_controlador_fsm;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic [2:0] umb_alto_in, umb_bajo_in;
  logic [7:0] empties, fifo_err;
  logic [4:0] state;
  logic [2:0] umb_alto, umb_bajo;
  logic       idle, error_out;
  logic [7:0] err_src;

  int n_cmp = 0;
  int n_bad = 0;

  controlador_fsm #(
    .N_FIFOS(8), .UMB_W(3), .UMB_ALTO_RST(6), .UMB_BAJO_RST(1)
  ) dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umb_alto_in(umb_alto_in), .umb_bajo_in(umb_bajo_in),
    .empties(empties), .fifo_err(fifo_err),
    .state(state), .umb_alto(umb_alto), .umb_bajo(umb_bajo),
    .idle(idle), .error_out(error_out), .err_src(err_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state codes straight from the encoding table
  localparam logic [4:0] E_RESET  = 5'b00001;
  localparam logic [4:0] E_INIT   = 5'b00010;
  localparam logic [4:0] E_IDLE   = 5'b00100;
  localparam logic [4:0] E_ACTIVE = 5'b01000;
  localparam logic [4:0] E_ERROR  = 5'b10000;

  typedef struct {
    logic       init;
    logic [2:0] ai, bi;
    logic [7:0] emp, fe;
    logic [4:0] st;
    logic [2:0] alto, bajo;
    logic       idl, er;
    logic [7:0] src;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] st, input logic [2:0] a,
                         input logic [2:0] b, input logic [7:0] src);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".umb_alto"}, 32'(umb_alto), 32'(a));
    chk({tag, ".umb_bajo"}, 32'(umb_bajo), 32'(b));
    chk({tag, ".idle"}, 32'(idle), 32'(st == E_IDLE));
    chk({tag, ".error_out"}, 32'(error_out), 32'(st == E_ERROR));
    chk({tag, ".err_src"}, 32'(err_src), 32'(src));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic [2:0] a, input logic [2:0] b,
                       input logic [7:0] e, input logic [7:0] f);
    init = i; umb_alto_in = a; umb_bajo_in = b; empties = e; fifo_err = f;
  endtask

  // Hold reset two cycles, release, one edge into INIT
  task automatic do_reset();
    drive(1'b1, 3'd6, 3'd1, 8'hFF, 8'h00);
    reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_held", E_RESET, 3'd6, 3'd1, 8'h00);
    reset_L = 1'b1;
    #1;
    chk("rst_released.state", 32'(state), 32'(E_RESET));
    step();
    chk_all("rst_first_edge", E_INIT, 3'd6, 3'd1, 8'h00);
  endtask

  // Behavioural reference: mode names, thresholds, error set since last config
  localparam int M_RESET = 0, M_INIT = 1, M_IDLE = 2, M_ACTIVE = 3, M_ERROR = 4;
  int         m_mode;
  logic [2:0] m_alto, m_bajo;
  logic [7:0] m_src;

  task automatic model_edge(input logic i, input logic [2:0] a, input logic [2:0] b,
                            input logic [7:0] e, input logic [7:0] f);
    int nm;
    nm = m_mode;
    if (m_mode == M_RESET) nm = M_INIT;
    else if (m_mode == M_INIT) begin
      m_alto = a; m_bajo = b;
      if (!i) nm = (int'(b) >= int'(a)) ? M_ERROR : M_IDLE;
    end else if (m_mode == M_IDLE || m_mode == M_ACTIVE) begin
      if (f != 0)         nm = M_ERROR;
      else if (i)         nm = M_INIT;
      else if (e == 8'hFF) nm = M_IDLE;
      else                nm = M_ACTIVE;
    end
    if (m_mode >= M_IDLE) m_src = m_src | f;
    if (nm == M_INIT) m_src = 8'h00;
    m_mode = nm;
  endtask

  initial begin
    reset_L = 1'b1;
    drive(1'b1, 3'd6, 3'd1, 8'hFF, 8'h00);
    #2;

    // ---- table-driven directed sequence ----
    vt[0] = '{1'b1, 3'd5, 3'd2, 8'hFF, 8'h00, E_INIT,   3'd5, 3'd2, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b0, 3'd5, 3'd2, 8'hFF, 8'h00, E_IDLE,   3'd5, 3'd2, 1'b1, 1'b0, 8'h00};
    vt[2] = '{1'b0, 3'd7, 3'd0, 8'hFE, 8'h00, E_ACTIVE, 3'd5, 3'd2, 1'b0, 1'b0, 8'h00};
    vt[3] = '{1'b0, 3'd7, 3'd0, 8'hFF, 8'h00, E_IDLE,   3'd5, 3'd2, 1'b1, 1'b0, 8'h00};
    vt[4] = '{1'b0, 3'd1, 3'd4, 8'h7F, 8'h00, E_ACTIVE, 3'd5, 3'd2, 1'b0, 1'b0, 8'h00};
    vt[5] = '{1'b1, 3'd1, 3'd4, 8'hFF, 8'h10, E_ERROR,  3'd5, 3'd2, 1'b0, 1'b1, 8'h10};
    vt[6] = '{1'b1, 3'd6, 3'd1, 8'hFF, 8'h00, E_ERROR,  3'd5, 3'd2, 1'b0, 1'b1, 8'h10};
    vt[7] = '{1'b0, 3'd6, 3'd1, 8'h00, 8'h01, E_ERROR,  3'd5, 3'd2, 1'b0, 1'b1, 8'h11};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(vt[k].init, vt[k].ai, vt[k].bi, vt[k].emp, vt[k].fe);
      step();
      chk_all($sformatf("vec%0d", k), vt[k].st, vt[k].alto, vt[k].bajo, vt[k].src);
      chk($sformatf("vec%0d.idle_tbl", k), 32'(idle), 32'(vt[k].idl));
      chk($sformatf("vec%0d.err_tbl", k), 32'(error_out), 32'(vt[k].er));
    end

    // Async reset while in ERROR with a non-empty error record
    #2 reset_L = 1'b0;
    #1 chk_all("async_rst_error", E_RESET, 3'd6, 3'd1, 8'h00);

    // ---- bad configuration: bajo above alto ----
    do_reset();
    drive(1'b1, 3'd2, 3'd3, 8'hFF, 8'h00);
    step();
    chk_all("badcfg_init", E_INIT, 3'd2, 3'd3, 8'h00);
    init = 1'b0;
    step();
    chk_all("badcfg_err", E_ERROR, 3'd2, 3'd3, 8'h00);

    // ---- equal thresholds are also rejected ----
    do_reset();
    drive(1'b0, 3'd3, 3'd3, 8'hFF, 8'h00);
    step();
    chk_all("eqcfg_err", E_ERROR, 3'd3, 3'd3, 8'h00);

    // ---- bajo one below alto accepted; fifo_err in INIT ignored ----
    do_reset();
    drive(1'b0, 3'd3, 3'd2, 8'hFF, 8'hFF);
    step();
    chk_all("okcfg_idle", E_IDLE, 3'd3, 3'd2, 8'h00);
    drive(1'b1, 3'd7, 3'd0, 8'h00, 8'h00);
    step();
    chk_all("idle_to_init", E_INIT, 3'd3, 3'd2, 8'h00);
    drive(1'b0, 3'd7, 3'd0, 8'h01, 8'h00);
    step();
    chk_all("reinit_idle", E_IDLE, 3'd7, 3'd0, 8'h00);

    // ---- reset mid-ACTIVE takes effect before the next edge ----
    drive(1'b0, 3'd7, 3'd0, 8'hEF, 8'h00);
    step();
    chk_all("pre_rst_active", E_ACTIVE, 3'd7, 3'd0, 8'h00);
    #3 reset_L = 1'b0;
    #1 chk_all("async_rst_active", E_RESET, 3'd6, 3'd1, 8'h00);

    // ---- randomized traffic against the reference model ----
    do_reset();
    m_mode = M_INIT; m_alto = 3'd6; m_bajo = 3'd1; m_src = 8'h00;
    for (int c = 0; c < 600; c++) begin
      logic       ri;
      logic [2:0] ra, rb;
      logic [7:0] re, rf;
      ri = ($urandom_range(0, 7) == 0);
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      re = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      rf = ($urandom_range(0, 24) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 39) == 0) begin
        reset_L = 1'b0;
        #1;
        chk_all($sformatf("rnd%0d.async_rst", c), E_RESET, 3'd6, 3'd1, 8'h00);
        reset_L = 1'b1;
        m_mode = M_RESET; m_alto = 3'd6; m_bajo = 3'd1; m_src = 8'h00;
      end
      drive(ri, ra, rb, re, rf);
      model_edge(ri, ra, rb, re, rf);
      step();
      chk_all($sformatf("rnd%0d", c), 5'(1 << m_mode), m_alto, m_bajo, m_src);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/controlador_fsm.md
CONTROLADOR_FSM -- requirements
Module: controlador_fsm

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): N_FIFOS, 8, number of monitored FIFOs (4 naranja + 4 morado); UMB_W, 3, threshold width; UMB_ALTO_RST, 6, almost-full threshold after reset; UMB_BAJO_RST, 1, almost-empty threshold after reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  request to (re)enter configuration.
- umb_alto_in  in  UMB_W  almost-full threshold proposed during INIT.
- umb_bajo_in  in  UMB_W  almost-empty threshold proposed during INIT.
- empties  in  N_FIFOS  per-FIFO empty flags; bit i = FIFO i.
- fifo_err  in  N_FIFOS  per-FIFO overflow/underflow error pulses.
- state  out  5  one-hot FSM state.
- umb_alto  out  UMB_W  active almost-full threshold distributed to all FIFOs.
- umb_bajo  out  UMB_W  active almost-empty threshold distributed to all FIFOs.
- idle  out  1  high only in IDLE.
- error_out  out  1  high only in ERROR.
- err_src  out  N_FIFOS  sticky record of which FIFOs raised fifo_err.
REQ-003 Reset SHALL be asynchronous and active-low on reset_L; there SHALL be exactly one clock, clk.

Function
REQ-004 state encoding SHALL be one-hot: RESET=5'b00001, INIT=5'b00010, IDLE=5'b00100, ACTIVE=5'b01000, ERROR=5'b10000.
REQ-005 All outputs SHALL be registered; idle and error_out SHALL be Moore decodes of the state register.
REQ-006 RESET SHALL go to INIT on the first rising clk edge after reset_L is released.
REQ-007 In INIT, umb_alto and umb_bajo SHALL load umb_alto_in and umb_bajo_in on every edge.
REQ-008 INIT SHALL transition on init==0:
- to ERROR if umb_bajo_in >= umb_alto_in;
- otherwise to IDLE.
REQ-009 In IDLE and ACTIVE, transitions SHALL follow this priority (highest first): any fifo_err bit set -> ERROR; init==1 -> INIT; empties-based transition.
REQ-010 IDLE SHALL go to ACTIVE when empties != all-ones; ACTIVE SHALL go to IDLE when empties == all-ones.
REQ-011 Outside INIT, umb_alto and umb_bajo SHALL hold their values.
REQ-012 err_src SHALL OR-accumulate fifo_err every cycle while not in RESET or INIT, and SHALL clear on entry to INIT.
REQ-013 ERROR SHALL be absorbing: it is left only through reset_L low. init SHALL be ignored in ERROR.
REQ-014 fifo_err asserted while in INIT SHALL be ignored (FIFOs are being configured).
REQ-015 Transition latency from any qualifying input to the state update SHALL be one clk edge.
REQ-016 Invalid or non-one-hot state values SHALL recover to RESET on the next edge.

Reset
REQ-017 While reset_L==0, the block SHALL asynchronously force:
- state=RESET;
- umb_alto=UMB_ALTO_RST, umb_bajo=UMB_BAJO_RST;
- idle=0, error_out=0, err_src=0.
REQ-018 Reset asserted in any state, including mid-ACTIVE or ERROR, SHALL take effect immediately without waiting for clk.

Structure
REQ-019 The state encodings and reset threshold constants SHALL live in a shared package used by the arbiters and FIFOs.
REQ-020 The block SHALL be one module containing the next-state logic and the registers. An optional sub-module, cfg_validador, SHALL perform the umb_bajo_in < umb_alto_in comparison.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset/init: reset_L=0 for 2 cycles, then 1 -> state=00001, then 00010 one edge after release; umb_alto=6, umb_bajo=1.
- Configuration: in INIT, umb_alto_in=5, umb_bajo_in=2, then init=0 -> state=00100, idle=1, umb_alto=5, umb_bajo=2.
- Activity: empties=8'hFE -> ACTIVE next edge; empties=8'hFF -> IDLE next edge; thresholds unchanged.
- Simultaneous events: in ACTIVE with fifo_err=8'h10, init=1 and empties=8'hFF on the same cycle -> ERROR, error_out=1, err_src=8'h10; a later init=1 keeps ERROR.
- Bad configuration: umb_alto_in=2, umb_bajo_in=3, init 1->0 -> ERROR.
- Reset mid-operation: reset_L low asynchronously in ACTIVE -> state=00001 before the next clk edge, all outputs at reset values.
